apb_uart_fifo_model: RTL

Parametrised APB UART model for the litmus/system testbenches. It is a 16550-style register file with real TX/RX FIFOs, divisor-paced transmission, a bench-driven RX injection port, loopback and prioritised interrupts. It replaces free-running character dumps with cycle-accurate LSR/IIR behaviour so that driver polling and interrupt paths are actually exercised. It sits on the peripheral APB segment; tx_* and rx_* connect to bench monitors and drivers.

---
 rtl/apb_uart_fifo_model.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_uart_fifo_model.sv
// rtl/apb_uart_fifo_model.sv - 16550-style APB UART model with TX/RX FIFOs, paced TX and IRQ
module apb_uart_fifo_model #(
  parameter int          FIFO_DEPTH = 16,
  parameter int          ADDR_SHIFT = 2,
  parameter logic [15:0] RESET_DIV  = 16'd1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic {IDLE, SHIFT} tx_state_t;

  // register file
  logic [7:0]  lcr, scr, dll, dlm;
  logic [3:0]  ier;
  logic [4:0]  mcr;
  logic        fifo_en, oe, thre_latch, irq_q;

  // FIFO storage and pointers
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0] tx_cnt, tx_cnt_next, rx_cnt, rx_cnt_next;

  // TX engine
  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  shreg_q, shreg_d, tx_char;
  logic        tx_pop, tx_done;

  logic        acc, wr, rd, dlab;
  logic [2:0]  idx;
  logic        thr_wr, rbr_rd, ier_wr, fcr_wr, iir_rd, lsr_rd;
  logic        fifo_toggle, tx_flush, rx_flush;
  logic        tx_empty, tx_full, tx_push, rx_empty, rx_full, rx_push, rx_pop;
  logic        loop, rx_in_valid, oe_set, thre_set, thre_clr, temt;
  logic [7:0]  rx_in_data;
  logic [15:0] div_eff;
  logic [3:0]  iid;
  logic [7:0]  iir, lsr, rdata;
  logic        unused_bits;

  assign unused_bits = ^{pwdata_i[31:8], paddr_i};

  assign acc  = psel_i & penable_i;
  assign wr   = acc & pwrite_i;
  assign rd   = acc & ~pwrite_i;
  assign idx  = paddr_i[ADDR_SHIFT +: 3];
  assign dlab = lcr[7];
  assign loop = mcr[4];

  assign thr_wr = wr & (idx == 3'd0) & ~dlab;
  assign rbr_rd = rd & (idx == 3'd0) & ~dlab;
  assign ier_wr = wr & (idx == 3'd1) & ~dlab;
  assign fcr_wr = wr & (idx == 3'd2);
  assign iir_rd = rd & (idx == 3'd2);
  assign lsr_rd = rd & (idx == 3'd5);

  // Changing the FIFO mode discards everything queued in both directions.
  assign fifo_toggle = fcr_wr & (pwdata_i[0] != fifo_en);
  assign tx_flush    = fcr_wr & (pwdata_i[2] | fifo_toggle);
  assign rx_flush    = fcr_wr & (pwdata_i[1] | fifo_toggle);

  assign tx_empty = (tx_cnt == '0);
  assign rx_empty = (rx_cnt == '0);
  assign tx_full  = fifo_en ? (tx_cnt == FULL_CNT) : ~tx_empty;
  assign rx_full  = fifo_en ? (rx_cnt == FULL_CNT) : ~rx_empty;
  assign tx_push  = thr_wr & ~tx_full;

  // In loopback the bench RX port is disconnected and the TX output feeds RX.
  assign rx_in_valid = loop ? tx_done : rx_valid_i;
  assign rx_in_data  = loop ? tx_char : rx_data_i;
  assign rx_push     = rx_in_valid & ~rx_full;
  assign oe_set      = rx_in_valid & rx_full;
  assign rx_pop      = rbr_rd & ~rx_empty;
  assign rx_ready_o  = ~rx_full;

  assign div_eff = ({dlm, dll} == 16'd0) ? 16'd1 : {dlm, dll};

  // next FIFO occupancies; a flush wins over any push/pop in the same cycle
  always_comb begin
    tx_cnt_next = tx_cnt;
    rx_cnt_next = rx_cnt;
    if (tx_flush) tx_cnt_next = '0;
    else if (tx_push & ~tx_pop) tx_cnt_next = tx_cnt + 1'b1;
    else if (~tx_push & tx_pop) tx_cnt_next = tx_cnt - 1'b1;
    if (rx_flush) rx_cnt_next = '0;
    else if (rx_push & ~rx_pop) rx_cnt_next = rx_cnt + 1'b1;
    else if (~rx_push & rx_pop) rx_cnt_next = rx_cnt - 1'b1;
  end

  // FIFO pointers and counts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      tx_cnt <= tx_cnt_next;
      rx_cnt <= rx_cnt_next;
      if (tx_flush) begin
        tx_wp <= '0; tx_rp <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + 1'b1;
        if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      end
      if (rx_flush) begin
        rx_wp <= '0; rx_rp <= '0;
      end else begin
        if (rx_push) rx_wp <= rx_wp + 1'b1;
        if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end
    end
  end

  // FIFO data storage (contents are don't-care while the count is zero)
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wp] <= pwdata_i[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_in_data;
  end

  // TX engine next state: first character after IDLE waits D-1 cycles so
  // its strobe lands D cycles after the THR write; back-to-back ones reload D.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    tx_pop  = 1'b0;
    tx_done = 1'b0;
    tx_char = shreg_q;
    case (state_q)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop = 1'b1;
          if (div_eff == 16'd1) begin
            tx_done = 1'b1;
            tx_char = tx_mem[tx_rp];
          end else begin
            state_d = SHIFT;
            cnt_d   = div_eff - 16'd1;
            shreg_d = tx_mem[tx_rp];
          end
        end
      end
      SHIFT: begin
        if (cnt_q == 16'd1) begin
          tx_done = 1'b1;
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            cnt_d   = div_eff;
            shreg_d = tx_mem[tx_rp];
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // TX engine state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      shreg_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  assign tx_valid_o = tx_done & ~loop;
  assign tx_data_o  = tx_valid_o ? tx_char : 8'd0;
  assign temt       = tx_empty & (state_q == IDLE);

  assign thre_set = ((tx_cnt != '0) & (tx_cnt_next == '0)) |
                    (ier_wr & pwdata_i[1] & ~ier[1] & tx_empty);
  assign thre_clr = thr_wr | (iir_rd & (iid == 4'h2));

  // interrupt identification by priority
  always_comb begin
    iid = 4'h1;
    if (ier[2] & oe)               iid = 4'h6;
    else if (ier[0] & ~rx_empty)   iid = 4'h4;
    else if (ier[1] & thre_latch)  iid = 4'h2;
  end

  assign iir = {fifo_en ? 2'b11 : 2'b00, 2'b00, iid};
  assign lsr = {1'b0, temt, tx_empty, 3'b000, oe, ~rx_empty};

  // register writes, sticky status bits and the registered interrupt line
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lcr <= 8'd0; ier <= 4'd0; mcr <= 5'd0; scr <= 8'd0;
      dll <= RESET_DIV[7:0]; dlm <= RESET_DIV[15:8];
      fifo_en <= 1'b0; oe <= 1'b0; thre_latch <= 1'b1; irq_q <= 1'b0;
    end else begin
      if (wr & dlab & (idx == 3'd0)) dll <= pwdata_i[7:0];
      if (wr & dlab & (idx == 3'd1)) dlm <= pwdata_i[7:0];
      if (ier_wr)                    ier <= pwdata_i[3:0];
      if (fcr_wr)                    fifo_en <= pwdata_i[0];
      if (wr & (idx == 3'd3))        lcr <= pwdata_i[7:0];
      if (wr & (idx == 3'd4))        mcr <= pwdata_i[4:0];
      if (wr & (idx == 3'd7))        scr <= pwdata_i[7:0];
      if (oe_set)                                oe <= 1'b1;
      else if (lsr_rd | (fcr_wr & pwdata_i[1]))  oe <= 1'b0;
      if (thre_set)      thre_latch <= 1'b1;
      else if (thre_clr) thre_latch <= 1'b0;
      irq_q <= ~iid[0];
    end
  end

  // APB read mux
  always_comb begin
    rdata = 8'd0;
    case (idx)
      3'd0: rdata = dlab ? dll : (rx_empty ? 8'd0 : rx_mem[rx_rp]);
      3'd1: rdata = dlab ? dlm : {4'd0, ier};
      3'd2: rdata = iir;
      3'd3: rdata = lcr;
      3'd4: rdata = {3'd0, mcr};
      3'd5: rdata = lsr;
      3'd6: rdata = 8'd0;
      3'd7: rdata = scr;
      default: rdata = 8'd0;
    endcase
  end

  assign prdata_o  = {24'd0, rdata};
  assign pready_o  = 1'b1;
  assign pslverr_o = 1'b0;
  assign irq_o     = irq_q;

endmodule
